// File: rtl/flanger_sweep.sv
// rtl/flanger_sweep.sv - triangular delay sweep generator for a flanger delay tap
//
// Purpose: produces a delay tap that ramps between delay_min and delay_max,
// with an optional dwell of HOLD_N sample strobes at each extreme.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - asynchronous active-low reset
//   clk_enable - sample strobe; state advances only when high
//   run        - 1 = sweep, 0 = park at delay_min
//   sync       - rising edge restarts the sweep at delay_min
//   rate       - enabled samples per delay step = rate + 1
//   delay_min  - lower sweep bound (unsigned)
//   delay_max  - upper sweep bound (unsigned)
//   delay      - registered delay tap
//   dir        - 1 while rising or dwelling at the top
//   wrap       - one-clk pulse when a full sweep period completes

module flanger_sweep #(
    parameter int DELAY_W = 6,
    parameter int RATE_W  = 8,
    parameter int HOLD_N  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk_enable,
    input  logic               run,
    input  logic               sync,
    input  logic [RATE_W-1:0]  rate,
    input  logic [DELAY_W-1:0] delay_min,
    input  logic [DELAY_W-1:0] delay_max,
    output logic [DELAY_W-1:0] delay,
    output logic               dir,
    output logic               wrap
);

    localparam int HOLD_W = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_N > 0) ? HOLD_N - 1 : 0);
    localparam bit NO_HOLD = (HOLD_N == 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RISE     = 3'd1,
        S_HOLD_TOP = 3'd2,
        S_FALL     = 3'd3,
        S_HOLD_BOT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DELAY_W-1:0] r_delay;
    logic [DELAY_W-1:0] w_delay_nxt;
    logic [RATE_W-1:0]  r_step_cnt;
    logic [RATE_W-1:0]  w_step_nxt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;
    logic               r_sync_d;

    logic               w_sync_rise;
    logic               w_step;
    logic               w_degen;
    logic               w_hold_done;
    logic [DELAY_W:0]   w_delay_inc;
    logic [DELAY_W:0]   w_min_inc;
    logic               w_at_top;
    logic               w_at_bot;

    // sync history is sampled only on strobes, so the edge is seen in sample time
    assign w_sync_rise = sync & ~r_sync_d;
    assign w_step      = (r_step_cnt == rate);
    assign w_degen     = (delay_min >= delay_max);
    assign w_hold_done = (r_hold_cnt == HOLD_LAST);

    // one extra bit so the bound compares never wrap at the ends of the range
    assign w_delay_inc = {1'b0, r_delay} + (DELAY_W+1)'(1);
    assign w_min_inc   = {1'b0, delay_min} + (DELAY_W+1)'(1);
    assign w_at_top    = (w_delay_inc >= {1'b0, delay_max});
    assign w_at_bot    = ({1'b0, r_delay} <= w_min_inc);

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_delay    <= '0;
            r_step_cnt <= '0;
            r_hold_cnt <= '0;
            r_wrap     <= 1'b0;
            r_sync_d   <= 1'b0;
        end else begin
            r_wrap <= clk_enable & w_wrap_nxt;
            if (clk_enable) begin
                r_state    <= w_state_nxt;
                r_delay    <= w_delay_nxt;
                r_step_cnt <= w_step_nxt;
                r_hold_cnt <= w_hold_nxt;
                r_sync_d   <= sync;
            end
        end
    end

    // next-state and datapath
    always_comb begin
        w_state_nxt = r_state;
        w_delay_nxt = r_delay;
        w_step_nxt  = r_step_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_wrap_nxt  = 1'b0;

        if (!run) begin
            w_state_nxt = S_IDLE;
            w_delay_nxt = delay_min;
            w_step_nxt  = '0;
            w_hold_nxt  = '0;
        end else if (r_state == S_IDLE || w_sync_rise || w_degen) begin
            // start, restart and collapsed-bounds all land at the bottom, rising
            w_state_nxt = S_RISE;
            w_delay_nxt = delay_min;
            w_step_nxt  = '0;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                S_RISE: begin
                    if (w_step) begin
                        w_step_nxt = '0;
                        if (w_at_top) begin
                            w_delay_nxt = delay_max;
                            w_hold_nxt  = '0;
                            w_state_nxt = NO_HOLD ? S_FALL : S_HOLD_TOP;
                        end else begin
                            w_delay_nxt = w_delay_inc[DELAY_W-1:0];
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + RATE_W'(1);
                    end
                end
                S_FALL: begin
                    if (w_step) begin
                        w_step_nxt = '0;
                        if (w_at_bot) begin
                            w_delay_nxt = delay_min;
                            w_wrap_nxt  = 1'b1;
                            w_hold_nxt  = '0;
                            w_state_nxt = NO_HOLD ? S_RISE : S_HOLD_BOT;
                        end else begin
                            w_delay_nxt = r_delay - DELAY_W'(1);
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + RATE_W'(1);
                    end
                end
                S_HOLD_TOP: begin
                    if (w_hold_done) begin
                        w_state_nxt = S_FALL;
                        w_hold_nxt  = '0;
                        w_step_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
                S_HOLD_BOT: begin
                    if (w_hold_done) begin
                        w_state_nxt = S_RISE;
                        w_hold_nxt  = '0;
                        w_step_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_delay_nxt = delay_min;
                    w_step_nxt  = '0;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // outputs, all taken from registers
    always_comb begin
        delay = r_delay;
        wrap  = r_wrap;
        dir   = (r_state == S_RISE) || (r_state == S_HOLD_TOP);
    end

endmodule
